direction_input: RTL and testbench
==================================

Name: direction_input

Overview:
- Input conditioner directly upstream of the top-level direction/movement logic.
- Synchronises and debounces the four active-low direction keys.
- Detects presses and holds one pending direction request until the movement logic consumes it at a cell boundary (take pulse).
- Replaces the bare one-flop button registers. Wall checks stay with the consumer.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a debounced level changes (5 ms at 50 MHz); minimum 2.
- SYNC_STAGES, 2, synchroniser flop depth per key; minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- btn_n  in  4  raw keys, active-low, asynchronous. Bit i maps to direction code i: 0 right, 1 down, 2 left, 3 up.
- take  in  1  one-cycle pulse from consumer: pending direction accepted.
- held  out  4  debounced key levels, active-high.
- press  out  4  one-cycle pulse per key on a debounced press.
- dir_valid  out  1  a pending direction exists.
- dir  out  2  pending direction code, meaningful only while dir_valid=1.

Behaviour:
- Reset (sync, active-high):
  - Synchroniser flops load 1 (released).
  - Debounced levels, counters, held, press, dir_valid and dir all become 0.
  - rst asserted mid-debounce or with a pending request discards everything. Output is clean on the cycle after rst falls.
- Synchroniser: SYNC_STAGES flops per key; the last stage is inverted to give s[i] (1 = pressed).
- Debounce (per key, independent):
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - If s[i]==held[i], counter clears.
  - Otherwise counter increments.
  - When counter==DEBOUNCE_CYCLES-1 and still differing: held[i] toggles on that edge and counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach held.
- Press detect: press[i] is registered, high for exactly one cycle, on the cycle after held[i] rises. Releases produce no pulse.
- Latency: a raw press steady from edge 0 gives held[i]=1 after edge SYNC_STAGES+DEBOUNCE_CYCLES-1. press[i] and dir_valid follow one edge later.
- Pending register. Update priority per cycle, highest first:
  1. Any press bit set: dir takes the lowest-index set bit; dir_valid=1. Newest press overrides an unconsumed older request. This also applies when take fires in the same cycle, in which case the new press wins and dir_valid stays 1.
  2. Else take and dir_valid: if any held bit is set, dir reloads the lowest-index held bit and dir_valid stays 1 (auto-repeat while held). Otherwise dir_valid=0 and dir keeps its old value.
  3. Else: no change.
- take while dir_valid=0 is ignored.
- The consumer samples dir in the same cycle it asserts take.
- Releasing a key does not cancel an already pending request.

Decomposition:
- Shared package:
  - Direction code localparams DIR_RIGHT=0, DIR_DOWN=1, DIR_LEFT=2, DIR_UP=3.
  - NUM_KEYS=4.
  - Lowest-index-set priority function (4-bit to 2-bit).
- Sub-module button_debouncer (one key): synchroniser, counter, held level, press pulse; parameters SYNC_STAGES and DEBOUNCE_CYCLES. Instantiated 4 times.
- The top level holds only the pending register and priority logic.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean press: btn_n=4'b1110 from cycle 0 and held.
  - held[0]=1 after edge 5.
  - press=4'b0001 for one cycle at edge 6.
  - dir_valid=1, dir=0.
  - Release gives no press pulse.
- Bounce rejection: btn_n[2] low for 3 cycles, high for 1, repeated 10 times.
  - held, press and dir_valid stay 0.
  - Then a steady low gives dir=2 at the expected latency.
- Override, simultaneity and no-hold consume:
  - Press key 1, then key 3 before any take: dir=3.
  - Keys 1 and 3 pressed in the same cycle: dir=1.
  - take with no key held: dir_valid=0 next cycle.
- Auto-repeat: hold key 3; take pulses every 8 cycles → dir_valid stays 1, dir=3 throughout. After release, the next take clears dir_valid.
- Take/press collision: dir_valid=1, dir=0; take coincides with press of key 2 → next cycle dir_valid=1, dir=2.
- Reset mid-operation: rst for 1 cycle while key 0 is held and pending.
  - All outputs 0 the next cycle.
  - A continued hold re-debounces and produces a fresh press pulse (edge 6 after rst release).

Source files
------------

// File: rtl/direction_input_pkg.sv
// Shared definitions for the direction input conditioner.
// Provides the direction codes, the key count and a lowest-index-set
// priority encoder shared by the debounced-key and pending logic.
package direction_input_pkg;

   localparam int NUM_KEYS = 4;

   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_UP    = 2'd3;

   // Lowest set bit wins, so simultaneous keys resolve deterministically.
   // An all-zero input returns DIR_RIGHT; callers only use it with a bit set.
   function automatic logic [1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
      logic [1:0] r;
      r = DIR_RIGHT;
      casez (v)
         4'b???1: r = DIR_RIGHT;
         4'b??10: r = DIR_DOWN;
         4'b?100: r = DIR_LEFT;
         4'b1000: r = DIR_UP;
         default: r = DIR_RIGHT;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/direction_input_debouncer.sv
// button_debouncer: one active-low asynchronous key to a clean level.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   btn_n    - raw key, active-low, asynchronous
//   held     - debounced level, active-high
//   press    - registered one-cycle pulse the cycle after held rises
//   rise     - combinational "held just rose" (press one cycle early),
//              lets the pending register update alongside press
module button_debouncer #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic held,
   output logic press,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt;
   logic                   held_d;
   logic                   s;

   // Last synchroniser stage, inverted: 1 = pressed.
   assign s    = ~sync_q[SYNC_STAGES-1];
   assign rise = held & ~held_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         cnt    <= '0;
         held   <= 1'b0;
         held_d <= 1'b0;
         press  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
         held_d <= held;
         press  <= rise;
         if (s == held) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // Input has differed for DEBOUNCE_CYCLES consecutive cycles.
            held <= ~held;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/direction_input.sv
// direction_input: debounces the four direction keys and holds one pending
// direction request until the movement logic takes it.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   btn_n     - raw keys, active-low (0 right, 1 down, 2 left, 3 up)
//   take      - consumer accepted the pending direction (samples dir now)
//   held      - debounced key levels, active-high
//   press     - one-cycle pulse per key on a debounced press
//   dir_valid - a pending direction exists
//   dir       - pending direction code, valid while dir_valid
module direction_input
   import direction_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] btn_n,
   input  logic                take,
   output logic [NUM_KEYS-1:0] held,
   output logic [NUM_KEYS-1:0] press,
   output logic                dir_valid,
   output logic [1:0]          dir
);

   logic [NUM_KEYS-1:0] rise;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      button_debouncer #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk  (clk),
         .rst  (rst),
         .btn_n(btn_n[i]),
         .held (held[i]),
         .press(press[i]),
         .rise (rise[i])
      );
   end

   // A fresh press always wins, even over a same-cycle take. A take with
   // keys still held reloads the request (auto-repeat); otherwise it
   // empties the slot and dir keeps its stale value.
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_valid <= 1'b0;
         dir       <= DIR_RIGHT;
      end else if (|rise) begin
         dir_valid <= 1'b1;
         dir       <= lowest_set(rise);
      end else if (take && dir_valid) begin
         if (|held) dir <= lowest_set(held);
         else       dir_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_direction_input.sv
// Directed bench for direction_input with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_direction_input;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_n;
   logic       take;
   logic [3:0] held;
   logic [3:0] press;
   logic       dir_valid;
   logic [1:0] dir;

   int checks = 0;
   int errors = 0;

   direction_input #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_n    (btn_n),
      .take     (take),
      .held     (held),
      .press    (press),
      .dir_valid(dir_valid),
      .dir      (dir)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic take_pulse();
      take = 1'b1;
      tick(1);
      take = 1'b0;
   endtask

   initial begin
      logic bad;
      int   guard;
      rst = 1'b1; btn_n = 4'hF; take = 1'b0;
      tick(3);
      chk("reset_held",  8'(held), 8'h0);
      chk("reset_press", 8'(press), 8'h0);
      chk("reset_valid", 8'(dir_valid), 8'h0);
      chk("reset_dir",   8'(dir), 8'h0);

      // Clean press of key 0: next edge is edge 0.
      rst = 1'b0; btn_n = 4'b1110;
      tick(5);
      chk("clean_held_e4", 8'(held), 8'h0);
      tick(1);
      chk("clean_held_e5", 8'(held), 8'h1);
      chk("clean_press_e5", 8'(press), 8'h0);
      chk("clean_valid_e5", 8'(dir_valid), 8'h0);
      tick(1);
      chk("clean_press_e6", 8'(press), 8'h1);
      chk("clean_valid_e6", 8'(dir_valid), 8'h1);
      chk("clean_dir_e6", 8'(dir), 8'h0);
      tick(1);
      chk("clean_press_e7", 8'(press), 8'h0);

      // Release: no pulse, pending request survives, take then empties it.
      btn_n = 4'hF; bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (press != 4'h0) bad = 1'b1;
      end
      chk("release_no_press", 8'(bad), 8'h0);
      chk("release_held", 8'(held), 8'h0);
      chk("release_keeps_valid", 8'(dir_valid), 8'h1);
      take_pulse();
      chk("take_no_hold_valid", 8'(dir_valid), 8'h0);

      // Bounce on key 2: 3 low, 1 high, ten times.
      bad = 1'b0;
      for (int r = 0; r < 10; r++) begin
         btn_n = 4'b1011;
         for (int i = 0; i < 3; i++) begin
            tick(1);
            if (held != 4'h0 || press != 4'h0 || dir_valid) bad = 1'b1;
         end
         btn_n = 4'hF;
         tick(1);
         if (held != 4'h0 || press != 4'h0 || dir_valid) bad = 1'b1;
      end
      chk("bounce_rejected", 8'(bad), 8'h0);
      btn_n = 4'b1011;
      tick(6);
      chk("bounce_then_held", 8'(held), 8'h4);
      chk("bounce_then_valid_early", 8'(dir_valid), 8'h0);
      tick(1);
      chk("bounce_then_press", 8'(press), 8'h4);
      chk("bounce_then_valid", 8'(dir_valid), 8'h1);
      chk("bounce_then_dir", 8'(dir), 8'h2);

      // Override: key 1 then key 3 without a take.
      btn_n = 4'hF; tick(8);
      btn_n = 4'b1101; tick(7);
      chk("ovr_first_dir", 8'(dir), 8'h1);
      btn_n = 4'b0111; tick(7);
      chk("ovr_second_dir", 8'(dir), 8'h3);
      chk("ovr_second_valid", 8'(dir_valid), 8'h1);
      btn_n = 4'hF; tick(8);
      chk("ovr_release_dir", 8'(dir), 8'h3);
      take_pulse();
      chk("ovr_take_clears", 8'(dir_valid), 8'h0);

      // Keys 1 and 3 together: lowest index wins.
      btn_n = 4'b0101; tick(7);
      chk("simul_press", 8'(press), 8'hA);
      chk("simul_dir", 8'(dir), 8'h1);

      // Auto-repeat on key 3 (key 1 released).
      btn_n = 4'b0111; tick(8);
      chk("rpt_held", 8'(held), 8'h8);
      bad = 1'b0;
      for (int r = 0; r < 4; r++) begin
         take_pulse();
         if (!dir_valid || dir != 2'd3) bad = 1'b1;
         tick(7);
      end
      chk("rpt_valid_dir", 8'(bad), 8'h0);
      chk("rpt_dir_after", 8'(dir), 8'h3);
      btn_n = 4'hF; tick(8);
      chk("rpt_release_valid", 8'(dir_valid), 8'h1);
      take_pulse();
      chk("rpt_take_clears", 8'(dir_valid), 8'h0);

      // Take/press collision.
      btn_n = 4'b1110; tick(7);
      chk("coll_pre_dir", 8'(dir), 8'h0);
      chk("coll_pre_valid", 8'(dir_valid), 8'h1);
      btn_n = 4'b1011;
      guard = 0;
      while (held[2] !== 1'b1 && guard < 20) begin
         tick(1);
         guard++;
      end
      chk("coll_wait_held2", 8'(held[2]), 8'h1);
      take_pulse();
      chk("coll_valid", 8'(dir_valid), 8'h1);
      chk("coll_dir", 8'(dir), 8'h2);
      chk("coll_press", 8'(press), 8'h4);

      // Reset with key 0 held and pending.
      btn_n = 4'b1110; tick(8);
      chk("rst_pre_held", 8'(held), 8'h1);
      chk("rst_pre_dir", 8'(dir), 8'h0);
      chk("rst_pre_valid", 8'(dir_valid), 8'h1);
      rst = 1'b1; tick(1); rst = 1'b0;
      chk("rst_held", 8'(held), 8'h0);
      chk("rst_press", 8'(press), 8'h0);
      chk("rst_valid", 8'(dir_valid), 8'h0);
      chk("rst_dir", 8'(dir), 8'h0);
      tick(6);
      chk("rst_re_held", 8'(held), 8'h1);
      chk("rst_re_press_early", 8'(press), 8'h0);
      tick(1);
      chk("rst_re_press", 8'(press), 8'h1);
      chk("rst_re_valid", 8'(dir_valid), 8'h1);
      chk("rst_re_dir", 8'(dir), 8'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
